// File: rtl/module_bin_to_bcd_seq.sv
// module_bin_to_bcd_seq: iterative double-dabble binary-to-BCD converter; BIN2BCD_BLANK_EN enables the leading-zero blank mask
module module_bin_to_bcd_seq #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [BIN_W-1:0]      i_bin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic [DIGITS-1:0]     o_blank
);
    localparam int CW = $clog2(BIN_W);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t                r_state, w_state_nxt;
    logic [BIN_W-1:0]      r_shift;
    logic [4*DIGITS-1:0]   r_work, w_adj, w_work_nxt, r_bcd;
    logic [CW-1:0]         r_cnt;
    logic                  w_load, w_last;
    always_comb begin
        w_adj = '0;
        for (int k = 0; k < DIGITS; k++)
            w_adj[4*k+:4] = r_work[4*k+:4] >= 4'd5 ? r_work[4*k+:4] + 4'd3 : r_work[4*k+:4];
    end
    // the top bit of the adjusted value falls off the shift; it is always zero when 10^DIGITS >= 2^BIN_W
    assign w_work_nxt = (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, r_shift[BIN_W-1]};
    assign w_load     = (r_state != SHIFT) && i_start;
    assign w_last     = (r_state == SHIFT) && (r_cnt == '0);
    always_comb begin
        w_state_nxt = IDLE;
        if (w_load)
            w_state_nxt = SHIFT;
        else if (r_state == SHIFT)
            w_state_nxt = w_last ? DONE : SHIFT;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_work  <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_shift <= i_bin;
                r_work  <= '0;
                r_cnt   <= CW'(BIN_W-1);
            end else if (r_state == SHIFT) begin
                r_shift <= r_shift << 1;
                r_work  <= w_work_nxt;
                r_cnt   <= r_cnt - 1'b1;
            end
            if (w_last)
                r_bcd <= w_work_nxt;
        end
    end
    assign o_busy = (r_state == SHIFT);
    assign o_done = (r_state == DONE);
    assign o_bcd  = r_bcd;
`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] r_blank, w_blank;
    logic              w_zero;
    always_comb begin
        w_blank = '0;
        w_zero  = 1'b1;
        for (int k = DIGITS-1; k >= 1; k--) begin
            w_zero     = w_zero && (w_work_nxt[4*k+:4] == 4'd0);
            w_blank[k] = w_zero;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_blank <= '0;
        else if (w_last)
            r_blank <= w_blank;
    end
    assign o_blank = r_blank;
`else
    assign o_blank = '0;
`endif
endmodule

// File: tb/tb_module_bin_to_bcd_seq.sv
// tb_module_bin_to_bcd_seq: randomized self-checking bench against a decimal-arithmetic reference model
module tb_module_bin_to_bcd_seq;
    logic        clk = 1'b0, rst = 1'b1;
    logic        sa = 1'b0, sb = 1'b0;
    logic [11:0] ba = '0;
    logic [15:0] bb = '0;
    logic        busy_a, done_a, busy_b, done_b;
    logic [15:0] bcd_a;
    logic [3:0]  blank_a;
    logic [19:0] bcd_b;
    logic [4:0]  blank_b;
    int tests = 0, fails = 0;

    module_bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(sa), .i_bin(ba),
        .o_busy(busy_a), .o_done(done_a), .o_bcd(bcd_a), .o_blank(blank_a));
    module_bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(sb), .i_bin(bb),
        .o_busy(busy_b), .o_done(done_b), .o_bcd(bcd_b), .o_blank(blank_b));

    always #5 clk = ~clk;

    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r = '0;
        for (int k = 0; k < 5; k++) begin
            r[4*k+:4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_blank(input int unsigned v);
        logic [3:0] r = '0;
`ifdef BIN2BCD_BLANK_EN
        for (int k = 1; k < 4; k++) r[k] = (v < 10**k);
`endif
        return r;
    endfunction

    task automatic run_a(input logic [11:0] v, input int ign_c, input int rst_c,
                         output int lat, output int busy_n, output int done_n,
                         output logic [15:0] bcd, output logic [3:0] blank,
                         output logic busy_rst, output logic [15:0] bcd_rst);
        lat = 0; busy_n = 0; done_n = 0; bcd = 'x; blank = 'x; busy_rst = 'x; bcd_rst = 'x;
        @(negedge clk); sa = 1'b1; ba = v;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (busy_a) busy_n++;
            if (done_a) begin
                if (lat == 0) lat = c;
                done_n++;
                bcd = bcd_a;
                blank = blank_a;
            end
            if (c == 1) begin sa = 1'b0; ba = 12'($urandom); end
            if (c == ign_c) begin sa = 1'b1; ba = 12'd42; end
            if (c == ign_c + 1) sa = 1'b0;
            if (c == rst_c) rst = 1'b1;
            if (c == rst_c + 1) begin rst = 1'b0; busy_rst = busy_a; bcd_rst = bcd_a; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy_a); end
        tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done_a); end
        tests++; if (bcd_a !== 16'h0) begin fails++; $display("FAIL reset_bcd got %h want 0000", bcd_a); end
        tests++; if (blank_a !== 4'h0) begin fails++; $display("FAIL reset_blank got %b want 0000", blank_a); end
        rst = 1'b0;
    endtask

    task automatic check_conv(input string nm, input logic [11:0] v);
        int lat, bn, dn; logic [15:0] bcd, br; logic [3:0] bl; logic bz;
        logic [19:0] e;
        e = ref_bcd(v);
        run_a(v, 0, -10, lat, bn, dn, bcd, bl, bz, br);
        tests++; if (lat !== 13) begin fails++; $display("FAIL %s_latency v=%0d got %0d want 13", nm, v, lat); end
        tests++; if (bn !== 12) begin fails++; $display("FAIL %s_busy_cycles v=%0d got %0d want 12", nm, v, bn); end
        tests++; if (dn !== 1) begin fails++; $display("FAIL %s_done_pulses v=%0d got %0d want 1", nm, v, dn); end
        tests++; if (bcd !== e[15:0]) begin fails++; $display("FAIL %s_bcd v=%0d got %h want %h", nm, v, bcd, e[15:0]); end
        tests++; if (bl !== ref_blank(v)) begin fails++; $display("FAIL %s_blank v=%0d got %b want %b", nm, v, bl, ref_blank(v)); end
    endtask

    task automatic test_max;
        check_conv("max", 12'd4095);
    endtask

    task automatic test_blank;
        check_conv("blank42", 12'd42);
        check_conv("blank0", 12'd0);
        check_conv("blank1000", 12'd1000);
    endtask

    task automatic test_random;
        for (int i = 0; i < 16; i++) check_conv("rand", 12'($urandom));
    endtask

    task automatic test_ignore_start;
        int lat, bn, dn; logic [15:0] bcd, br; logic [3:0] bl; logic bz;
        run_a(12'd1234, 5, -10, lat, bn, dn, bcd, bl, bz, br);
        tests++; if (bcd !== 16'h1234) begin fails++; $display("FAIL ignore_bcd got %h want 1234", bcd); end
        tests++; if (dn !== 1) begin fails++; $display("FAIL ignore_done_pulses got %0d want 1", dn); end
        tests++; if (lat !== 13) begin fails++; $display("FAIL ignore_latency got %0d want 13", lat); end
    endtask

    task automatic test_reset_mid;
        int lat, bn, dn; logic [15:0] bcd, br; logic [3:0] bl; logic bz;
        run_a(12'd2048, 6, 6, lat, bn, dn, bcd, bl, bz, br);
        tests++; if (bz !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b want 0", bz); end
        tests++; if (br !== 16'h0) begin fails++; $display("FAIL midrst_bcd got %h want 0000", br); end
        tests++; if (dn !== 0) begin fails++; $display("FAIL midrst_done_pulses got %0d want 0", dn); end
        check_conv("after_rst", 12'd7);
    endtask

    task automatic test_back_to_back;
        int c;
        @(negedge clk); sa = 1'b1; ba = 12'd0;
        @(negedge clk); sa = 1'b0;
        c = 1;
        while (!done_a && c < 30) begin @(negedge clk); c++; end
        tests++; if (c !== 13) begin fails++; $display("FAIL b2b_first_latency got %0d want 13", c); end
        tests++; if (bcd_a !== 16'h0000) begin fails++; $display("FAIL b2b_first_bcd got %h want 0000", bcd_a); end
        sa = 1'b1; ba = 12'd999;
        @(negedge clk); sa = 1'b0; ba = 12'($urandom);
        tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL b2b_no_gap busy got %b want 1", busy_a); end
        c = 1;
        while (!done_a && c < 30) begin @(negedge clk); c++; end
        tests++; if (c !== 13) begin fails++; $display("FAIL b2b_second_latency got %0d want 13", c); end
        tests++; if (bcd_a !== 16'h0999) begin fails++; $display("FAIL b2b_second_bcd got %h want 0999", bcd_a); end
        @(negedge clk);
        tests++; if (done_a !== 1'b0 || bcd_a !== 16'h0999) begin fails++; $display("FAIL b2b_hold done=%b bcd=%h want 0 0999", done_a, bcd_a); end
    endtask

    task automatic test_wide;
        int c;
        logic [15:0] v;
        logic [19:0] e;
        for (int i = 0; i < 4; i++) begin
            v = (i == 0) ? 16'hFFFF : 16'($urandom);
            e = ref_bcd(v);
            @(negedge clk); sb = 1'b1; bb = v;
            @(negedge clk); sb = 1'b0; bb = 16'($urandom);
            c = 1;
            while (!done_b && c < 40) begin @(negedge clk); c++; end
            tests++; if (c !== 17) begin fails++; $display("FAIL wide_latency v=%0d got %0d want 17", v, c); end
            tests++; if (bcd_b !== e) begin fails++; $display("FAIL wide_bcd v=%0d got %h want %h", v, bcd_b, e); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_blank();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
